kbdin: RTL and testbench



---
 rtl/kbdin_pkg.sv | 25 ++
 rtl/kbdin_bytefifo.sv | 60 ++++++
 rtl/kbdin.sv | 177 +++++++++++++++++
 tb/tb_kbdin.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbdin_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: register map,
// STAT bit positions, receiver state encoding and a parity helper.
package kbdin_pkg;

    // Register addresses
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    // STAT bit positions
    localparam int STAT_OVF  = 7;
    localparam int STAT_PERR = 6;
    localparam int STAT_FERR = 5;

    // Receiver FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    // Odd parity over data bits plus parity bit means a good frame
    function automatic logic parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/kbdin_bytefifo.sv
// Synchronous 8-bit FIFO with push, pop, flush and occupancy reporting.
// Push while full is dropped unless a pop happens in the same cycle.
module bytefifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [7:0]             i_wdata,
    output logic [7:0]             o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | i_pop);

    // Pointer and occupancy bookkeeping; flush empties the queue
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; a flush in the same cycle discards the byte
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/kbdin.sv
// PS/2 keyboard receiver: pin synchronisers, falling-edge detect,
// 11-bit frame deframer with timeout, error flags, byte FIFO and a
// small CPU register file (DATA / STAT / CTRL).
module kbdin
    import kbdin_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 25000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] addrin,
    input  logic [7:0] datain,
    input  logic       inen,
    input  logic       rden,
    output logic [7:0] dataout,
    output logic       avail,
    input  logic       ps2clk,
    input  logic       ps2data
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          r_clk_s1, r_clk_s2, r_clk_prev;
    logic          r_dat_s1, r_dat_s2;
    logic [1:0]    r_state;
    logic [3:0]    r_bitcnt;
    logic [10:0]   r_shift;
    logic [TW-1:0] r_tocnt;
    logic          r_ovf, r_perr, r_ferr;
    logic [7:0]    r_dataout;

    logic          w_fall;
    logic          w_in_check;
    logic          w_frame_bad;
    logic          w_par_bad;
    logic          w_push;
    logic          w_timeout;
    logic          w_pop;
    logic          w_flush;
    logic          w_wr_stat;
    logic          w_ovf_set;
    logic [7:0]    w_rdata;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_cnt_ext;
    logic [7:0]    w_stat;
    logic          w_unused;

    // Two-flop synchronisers plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s2;

    // Frame deframer: shift bits LSB first, abort on inter-edge timeout
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_tocnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bitcnt <= '0;
                    r_tocnt  <= '0;
                    if (w_fall) begin
                        r_shift  <= {r_dat_s2, r_shift[10:1]};
                        r_bitcnt <= 4'd1;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_fall) begin
                        r_shift  <= {r_dat_s2, r_shift[10:1]};
                        r_tocnt  <= '0;
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd10) r_state <= ST_CHECK;
                    end else if (r_tocnt == TW'(TIMEOUT)) begin
                        r_tocnt  <= '0;
                        r_bitcnt <= '0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_tocnt <= r_tocnt + TW'(1);
                    end
                end
                ST_CHECK: begin
                    r_bitcnt <= '0;
                    r_tocnt  <= '0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Frame layout after 11 shifts: [0] start, [8:1] data, [9] parity, [10] stop
    assign w_in_check  = (r_state == ST_CHECK);
    assign w_frame_bad = w_in_check & (r_shift[0] | ~r_shift[10]);
    assign w_par_bad   = w_in_check & ~r_shift[0] & r_shift[10] & ~parity_ok(r_shift[9:1]);
    assign w_push      = w_in_check & ~r_shift[0] & r_shift[10] & parity_ok(r_shift[9:1]);
    assign w_timeout   = (r_state == ST_SHIFT) & ~w_fall & (r_tocnt == TW'(TIMEOUT));

    assign w_pop     = rden & (addrin == REG_DATA);
    assign w_wr_stat = inen & (addrin == REG_STAT);
    assign w_flush   = inen & (addrin == REG_CTRL) & datain[0];
    // A pop alongside a full push frees a slot; a flush silently discards
    assign w_ovf_set = w_push & w_full & ~w_pop & ~w_flush;

    bytefifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (r_shift[8:1]),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sticky error flags; a set event beats a simultaneous W1C
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_ovf  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_ovf_set)                         r_ovf  <= 1'b1;
            else if (w_wr_stat && datain[STAT_OVF])  r_ovf  <= 1'b0;
            if (w_par_bad)                         r_perr <= 1'b1;
            else if (w_wr_stat && datain[STAT_PERR]) r_perr <= 1'b0;
            if (w_frame_bad || w_timeout)          r_ferr <= 1'b1;
            else if (w_wr_stat && datain[STAT_FERR]) r_ferr <= 1'b0;
        end
    end

    assign w_cnt_ext = 8'(w_count);
    assign w_stat    = {r_ovf, r_perr, r_ferr, 1'b0, w_cnt_ext[3:0]};

    // Registered read port; holds its value until the next read strobe
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_dataout <= '0;
        end else if (rden) begin
            case (addrin)
                REG_DATA: r_dataout <= w_empty ? 8'h00 : w_rdata;
                REG_STAT: r_dataout <= w_stat;
                default:  r_dataout <= 8'h00;
            endcase
        end
    end

    assign dataout  = r_dataout;
    assign avail    = ~w_empty;
    assign w_unused = ^{datain[4:1], w_cnt_ext[7:4]};

endmodule

// File: tb/tb_kbdin.sv
// Self-checking bench for kbdin: table of single frames, hand-written
// multi-frame corner cases, then random traffic against a queue model.
module tb_kbdin;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 100;
    localparam int H       = 12;   // PS/2 half-period in clk cycles

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [1:0] addrin = '0;
    logic [7:0] datain = '0;
    logic       inen = 1'b0;
    logic       rden = 1'b0;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic [7:0] dataout;
    logic       avail;

    kbdin #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .addrin  (addrin),
        .datain  (datain),
        .inen    (inen),
        .rden    (rden),
        .dataout (dataout),
        .avail   (avail),
        .ps2clk  (ps2clk),
        .ps2data (ps2data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue plus three sticky flags
    logic [7:0] q[$];
    bit m_ovf, m_perr, m_ferr;

    typedef struct {
        logic [7:0] d;
        bit         bpar;
        bit         bstop;
        bit         bstart;
        logic [7:0] exp_stat;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        rden = 1'b1;
        addrin = a;
        tick();
        rden = 1'b0;
        v = dataout;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        inen = 1'b1;
        addrin = a;
        datain = d;
        tick();
        inen = 1'b0;
    endtask

    // Drive nbits of a frame; optionally issue a DATA read in the CHECK cycle
    task automatic send_frame(input logic [7:0] d, input bit bpar, input bit bstop,
                              input bit bstart, input int nbits, input bit pop_at_check,
                              output logic [7:0] popped);
        logic [10:0] f;
        f = {~bstop, (~^d) ^ bpar, d, bstart};
        popped = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            ps2data = f[i];
            repeat (H) tick();
            ps2clk = 1'b0;
            if (pop_at_check && i == 10) begin
                repeat (3) @(posedge clk);
                #1;
                rden = 1'b1;
                addrin = 2'd0;
                tick();
                rden = 1'b0;
                popped = dataout;
                repeat (H - 4) tick();
            end else begin
                repeat (H) tick();
            end
            ps2clk = 1'b1;
        end
        ps2data = 1'b1;
        repeat (4) tick();
    endtask

    function automatic logic [7:0] m_stat();
        logic [7:0] n;
        n = 8'(q.size());
        return {m_ovf, m_perr, m_ferr, 1'b0, n[3:0]};
    endfunction

    task automatic m_frame(input logic [7:0] d, input bit bpar, input bit bstop,
                           input bit bstart, input int nbits);
        if (nbits < 11 || bstart || bstop) m_ferr = 1'b1;
        else if (bpar)                     m_perr = 1'b1;
        else if (q.size() >= DEPTH)        m_ovf  = 1'b1;
        else                               q.push_back(d);
    endtask

    initial begin
        logic [7:0] v, p, exp;
        int r;
        bit bp, bs;

        tbl[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h01, 8'h1C};
        tbl[1] = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h40, 8'h00};
        tbl[2] = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00};
        tbl[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h20, 8'h00};
        tbl[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'h01, 8'hFF};
        tbl[5] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'h20, 8'h00};

        repeat (3) tick();
        chk("reset_dataout", dataout, 8'h00);
        chk("reset_avail", {7'd0, avail}, 8'h00);
        n_rst = 1'b1;
        tick();
        rd(2'd1, v);
        chk("reset_stat", v, 8'h00);

        // Single-frame table
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].d, tbl[i].bpar, tbl[i].bstop, tbl[i].bstart, 11, 1'b0, p);
            chk("tbl_avail", {7'd0, avail}, {7'd0, tbl[i].exp_stat[0]});
            rd(2'd1, v);
            chk("tbl_stat", v, tbl[i].exp_stat);
            rd(2'd0, v);
            chk("tbl_data", v, tbl[i].exp_data);
            chk("tbl_avail_after", {7'd0, avail}, 8'h00);
            wr(2'd1, 8'hE0);
            rd(2'd1, v);
            chk("tbl_stat_clr", v, 8'h00);
        end

        // Nine frames into an 8-deep FIFO
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 11, 1'b0, p);
        rd(2'd1, v);
        chk("ovf_stat", v, 8'h88);
        for (int i = 1; i <= 8; i++) begin
            rd(2'd0, v);
            chk("ovf_data", v, 8'(i));
        end
        rd(2'd0, v);
        chk("ovf_empty_read", v, 8'h00);
        wr(2'd1, 8'h80);
        rd(2'd1, v);
        chk("ovf_clr", v, 8'h00);

        // Truncated frame, then timeout, then a good frame
        send_frame(8'h33, 1'b0, 1'b0, 1'b0, 5, 1'b0, p);
        repeat (TIMEOUT + 50) tick();
        rd(2'd1, v);
        chk("timeout_stat", v, 8'h20);
        wr(2'd1, 8'h20);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 11, 1'b0, p);
        rd(2'd1, v);
        chk("after_to_stat", v, 8'h01);
        rd(2'd0, v);
        chk("after_to_data", v, 8'hF0);

        // Full FIFO with a DATA read landing in the CHECK cycle
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 11, 1'b0, p);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 11, 1'b1, p);
        chk("fullpop_popped", p, 8'h01);
        rd(2'd1, v);
        chk("fullpop_stat", v, 8'h08);
        for (int i = 2; i <= 8; i++) begin
            rd(2'd0, v);
            chk("fullpop_data", v, 8'(i));
        end
        rd(2'd0, v);
        chk("fullpop_last", v, 8'hAA);

        // Flush via CTRL
        for (int i = 0; i < 3; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, 11, 1'b0, p);
        chk("flush_pre_avail", {7'd0, avail}, 8'h01);
        wr(2'd2, 8'h01);
        chk("flush_avail", {7'd0, avail}, 8'h00);
        rd(2'd1, v);
        chk("flush_stat", v, 8'h00);

        // Reset in the middle of a frame
        for (int i = 0; i < 3; i++) send_frame(8'h60 + 8'(i), 1'b0, 1'b0, 1'b0, 11, 1'b0, p);
        rd(2'd1, v);
        chk("prerst_stat", v, 8'h03);
        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 5, 1'b0, p);
        n_rst = 1'b0;
        repeat (2) tick();
        chk("rst_dataout", dataout, 8'h00);
        chk("rst_avail", {7'd0, avail}, 8'h00);
        n_rst = 1'b1;
        tick();
        rd(2'd1, v);
        chk("rst_stat", v, 8'h00);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 11, 1'b0, p);
        rd(2'd0, v);
        chk("rst_next_frame", v, 8'h5A);

        // Random traffic against the model
        q.delete();
        m_ovf = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 10));
            if (r <= 4) begin
                v = 8'($urandom);
                bp = ($urandom_range(0, 7) == 0);
                bs = ($urandom_range(0, 7) == 0);
                send_frame(v, bp, bs, 1'b0, 11, 1'b0, p);
                m_frame(v, bp, bs, 1'b0, 11);
                chk("rnd_avail", {7'd0, avail}, {7'd0, q.size() != 0});
            end else if (r <= 6) begin
                exp = (q.size() != 0) ? q.pop_front() : 8'h00;
                rd(2'd0, v);
                chk("rnd_data", v, exp);
            end else if (r == 7) begin
                exp = m_stat();
                rd(2'd1, v);
                chk("rnd_stat", v, exp);
            end else if (r == 8) begin
                p = 8'($urandom);
                wr(2'd1, p);
                if (p[7]) m_ovf = 1'b0;
                if (p[6]) m_perr = 1'b0;
                if (p[5]) m_ferr = 1'b0;
            end else if (r == 9) begin
                if ($urandom_range(0, 2) == 0) begin
                    wr(2'd2, 8'h01);
                    q.delete();
                end else begin
                    wr(2'd3, 8'hFF);
                end
            end else begin
                rd(2'(2 + $urandom_range(0, 1)), v);
                chk("rnd_unmapped", v, 8'h00);
            end
        end
        exp = m_stat();
        rd(2'd1, v);
        chk("rnd_final_stat", v, exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
